// File: rtl/dec_key_sched_if.sv
// Key-schedule bus: key load/zeroize strobes, round index, key readout.
// key_zeroize exists only when DKS_ZEROIZE_EN is defined.
interface dec_key_sched_if #(
  parameter int KW = 128
);
  logic          key_load;
  logic [KW-1:0] key_in;
  logic [3:0]    rk_idx;
  logic [KW-1:0] rk_out;
  logic          rk_valid;
  logic          busy;
  logic          keys_ready;
`ifdef DKS_ZEROIZE_EN
  logic          key_zeroize;

  modport master (
    output key_load, key_in, rk_idx, key_zeroize,
    input  rk_out, rk_valid, busy, keys_ready
  );

  modport slave (
    input  key_load, key_in, rk_idx, key_zeroize,
    output rk_out, rk_valid, busy, keys_ready
  );
`else
  modport master (
    output key_load, key_in, rk_idx,
    input  rk_out, rk_valid, busy, keys_ready
  );

  modport slave (
    input  key_load, key_in, rk_idx,
    output rk_out, rk_valid, busy, keys_ready
  );
`endif
endinterface

// File: rtl/dec_key_sched.sv
// AES-128 round-key expansion, one key per cycle, served last-round-first.
// Optional DKS_ZEROIZE_EN adds key_zeroize to wipe all key material.
module dec_key_sched #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input logic            clk,
  input logic            rst_an,
  dec_key_sched_if.slave bus
);

  localparam int NK = NR + 1;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [3:0]    rc_q;
  logic [7:0]    rcon_q;
  logic [KW-1:0] slot_q [NK];
  logic [KW-1:0] rk_out_q;
  logic          rk_valid_q;

  logic          load_en;
  logic          step_en;
  logic          last_step;
  logic          zero_en;
  logic [KW-1:0] prev;
  logic [KW-1:0] next_key;
  logic [KW-1:0] rd_key;
  logic          rd_hit;

  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   rot, sub, t;
  logic [31:0]   n0, n1, n2, n3;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef DKS_ZEROIZE_EN
  assign zero_en = bus.key_zeroize;
`else
  assign zero_en = 1'b0;
`endif

  assign last_step = (rc_q == 4'(NR));

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    step_en = 1'b0;
    if (zero_en) begin
      state_d = IDLE;
    end else begin
      unique case (1'b1)
        (state_q == IDLE),
        (state_q == READY): begin
          if (bus.key_load) begin
            load_en = 1'b1;
            state_d = EXPAND;
          end
        end
        (state_q == EXPAND): begin
          step_en = 1'b1;
          if (last_step) state_d = READY;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    prev = '0;
    for (int i = 0; i < NR; i++) begin
      if (rc_q == 4'(i + 1)) prev = slot_q[i];
    end
  end

  assign w0  = prev[127:96];
  assign w1  = prev[95:64];
  assign w2  = prev[63:32];
  assign w3  = prev[31:0];
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]),
                sbox(rot[15:8]), sbox(rot[7:0])};
  assign t   = sub ^ {rcon_q, 24'h0};
  assign n0  = w0 ^ t;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // Decryption order: index 0 is the last encryption round key.
  always_comb begin
    rd_hit = (state_q == READY) && (bus.rk_idx <= 4'(NR));
    rd_key = '0;
    for (int i = 0; i < NK; i++) begin
      if (rd_hit && (bus.rk_idx == 4'(NR - i))) rd_key = slot_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      rc_q       <= '0;
      rcon_q     <= '0;
      rk_out_q   <= '0;
      rk_valid_q <= 1'b0;
      for (int i = 0; i < NK; i++) slot_q[i] <= '0;
    end else if (zero_en) begin
      rc_q       <= '0;
      rcon_q     <= '0;
      rk_out_q   <= '0;
      rk_valid_q <= 1'b0;
      for (int i = 0; i < NK; i++) slot_q[i] <= '0;
    end else begin
      if (load_en) begin
        slot_q[0] <= bus.key_in;
        rc_q      <= 4'd1;
        rcon_q    <= 8'h01;
      end else if (step_en) begin
        for (int i = 1; i < NK; i++) begin
          if (rc_q == 4'(i)) slot_q[i] <= next_key;
        end
        rc_q   <= last_step ? 4'd0 : rc_q + 4'd1;
        rcon_q <= last_step ? 8'h00 : xtime(rcon_q);
      end
      rk_out_q   <= rd_key;
      rk_valid_q <= rd_hit;
    end
  end

  assign bus.rk_out     = rk_out_q;
  assign bus.rk_valid   = rk_valid_q;
  assign bus.busy       = (state_q == EXPAND);
  assign bus.keys_ready = (state_q == READY);

endmodule
